// File: rtl/adc_serial_ctrl.sv
// Serial front-end for a 12-bit 3-wire ADC: drives cs_n/sclk, shifts in one LEAD+R bit frame, emits a parallel sample.
// Latency: start edge to valid = 2*DIV*(LEAD+R)+1 clk; each frame occupies 2*DIV*(LEAD+R)+2+QUIET clk.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped, and valid is a one-cycle strobe.
module adc_serial_ctrl #(
  parameter int R     = 12,
  parameter int LEAD  = 4,
  parameter int DIV   = 4,
  parameter int QUIET = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sdata,
  output logic         cs_n,
  output logic         sclk,
  output logic [R-1:0] data,
  output logic         valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int FW = LEAD + R;
  localparam int BW = $clog2(FW + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FW - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'((QUIET > 0) ? QUIET - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE,
    ST_QUIET
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [QW-1:0] quiet_cnt, quiet_n;
  logic [FW-1:0] shift, shift_n;
  logic          cs_n_n, sclk_n, valid_n, ferr_n;
  logic [R-1:0]  data_n;

  // Every state other than IDLE counts as busy, including the quiet gap.
  assign busy = (state != ST_IDLE);

  // State register and all registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cs_n      <= cs_n_n;
      sclk      <= sclk_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      quiet_cnt <= quiet_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state and next-output logic; registers hold unless a state says otherwise.
  always_comb begin
    state_n = state;
    cs_n_n  = cs_n;
    sclk_n  = sclk;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    quiet_n = quiet_cnt;
    shift_n = shift;
    data_n  = data;
    ferr_n  = frame_err;
    valid_n = 1'b0;

    case (state)
      ST_IDLE: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b1;
        if (start) begin
          state_n = ST_CONV;
          cs_n_n  = 1'b0;
          div_n   = '0;
          bit_n   = '0;
          shift_n = '0;
        end
      end

      ST_CONV: begin
        if (div_cnt == DIV_LAST) begin
          div_n  = '0;
          sclk_n = ~sclk;
          // The ADC updates sdata after each falling edge, so it is
          // mid-window and stable when our own rising edge is generated.
          if (!sclk) begin
            shift_n = {shift[FW-2:0], sdata};
            bit_n   = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              // Frame complete: sclk is left high, no trailing falling edge.
              state_n = ST_DONE;
              cs_n_n  = 1'b1;
            end
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end

      ST_DONE: begin
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
        data_n  = shift[R-1:0];
        ferr_n  = |shift[FW-1:R];
        valid_n = 1'b1;
        quiet_n = '0;
        state_n = (QUIET == 0) ? ST_IDLE : ST_QUIET;
      end

      ST_QUIET: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b1;
        if (quiet_cnt == QUIET_LAST) begin
          state_n = ST_IDLE;
        end else begin
          quiet_n = quiet_cnt + QW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
      end
    endcase
  end

endmodule
